// File: rtl/alu_pkg.sv
// alu_pkg: op codes, flag bit positions and a zero-test helper for the
// LR35902 ALU. Flags travel as a nibble {Z,N,H,C}, bit3..bit0.
package alu_pkg;
  localparam logic [7:0] OP_ADD   = 8'h00;
  localparam logic [7:0] OP_ADC   = 8'h01;
  localparam logic [7:0] OP_SUB   = 8'h02;
  localparam logic [7:0] OP_SBC   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_XOR   = 8'h05;
  localparam logic [7:0] OP_OR    = 8'h06;
  localparam logic [7:0] OP_CP    = 8'h07;
  localparam logic [7:0] OP_RLC   = 8'h08;
  localparam logic [7:0] OP_RRC   = 8'h09;
  localparam logic [7:0] OP_RL    = 8'h0A;
  localparam logic [7:0] OP_RR    = 8'h0B;
  localparam logic [7:0] OP_DAA   = 8'h0C;
  localparam logic [7:0] OP_CPL   = 8'h0D;
  localparam logic [7:0] OP_SCF   = 8'h0E;
  localparam logic [7:0] OP_CCF   = 8'h0F;
  localparam logic [7:0] OP_SLA   = 8'h10;
  localparam logic [7:0] OP_SRA   = 8'h11;
  localparam logic [7:0] OP_SRL   = 8'h12;
  localparam logic [7:0] OP_SWAP  = 8'h13;
  localparam logic [7:0] OP_ADD16 = 8'h14;
  // Bit ops: base + bit index in op[2:0]
  localparam logic [7:0] OP_BIT   = 8'h18;
  localparam logic [7:0] OP_RES   = 8'h20;
  localparam logic [7:0] OP_SET   = 8'h28;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_H = 1;
  localparam int FLAG_C = 0;

  function automatic logic is_zero(input logic [7:0] v);
    return (v == 8'h00);
  endfunction
endpackage

// File: rtl/alu_if.sv
// alu_if: operand/result bundle between the CPU sequencer (master) and
// the ALU (slave).
//   op      8   operation code
//   X, Y    16  operands (8-bit ops use [7:0])
//   F       4   incoming flags {Z,N,H,C}
//   O       16  registered result
//   FResult 4   registered flags {Z,N,H,C}
interface alu_if;
  logic [7:0]  op;
  logic [15:0] X;
  logic [15:0] Y;
  logic [3:0]  F;
  logic [15:0] O;
  logic [3:0]  FResult;

  modport master (output op, X, Y, F, input O, FResult);
  modport slave  (input op, X, Y, F, output O, FResult);
endinterface

// File: rtl/alu_daa.sv
// alu_daa: combinational BCD correction after an 8-bit add/sub.
//   a_i      8  accumulator value
//   n_i,h_i,c_i  incoming N/H/C flags
//   r_o      8  corrected value
//   c_o      1  new carry (set when the 0x60 correction applies)
module alu_daa (
  input  logic [7:0] a_i,
  input  logic       n_i,
  input  logic       h_i,
  input  logic       c_i,
  output logic [7:0] r_o,
  output logic       c_o
);
  logic lo_adj, hi_adj;
  logic [7:0] corr;

  // After a subtract only the recorded H/C drive correction; after an add
  // the digit ranges of the raw value also do.
  assign lo_adj = h_i | (~n_i & (a_i[3:0] > 4'h9));
  assign hi_adj = c_i | (~n_i & (a_i > 8'h99));
  assign corr   = {(hi_adj ? 4'h6 : 4'h0), (lo_adj ? 4'h6 : 4'h0)};
  assign r_o    = n_i ? (a_i - corr) : (a_i + corr);
  assign c_o    = hi_adj;
endmodule

// File: rtl/alu.sv
// alu: LR35902 ALU, combinational core with registered result/flags.
//   clk, rst_n  clock, async active-low reset (clears O/FResult)
//   bus         alu_if.slave: op/X/Y/F in, O/FResult out (1-cycle latency)
// Optional: define ALU_BITOPS_EN to implement BIT/RES/SET (0x18-0x2F);
// otherwise those codes act as unassigned (O=X, FResult=F).
module alu
  import alu_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  alu_if.slave bus
);
  logic [7:0]  x8, y8;
  logic        cin;
  logic [8:0]  add9, sub9;
  logic [4:0]  addh, subh;
  logic [16:0] add17;
  logic [12:0] add13;
  logic [7:0]  sh_r, daa_r;
  logic        sh_c, daa_c;
  logic [15:0] o_d, o_q;
  logic [3:0]  f_d, f_q;

  assign x8  = bus.X[7:0];
  assign y8  = bus.Y[7:0];
  assign cin = ((bus.op == OP_ADC) || (bus.op == OP_SBC)) & bus.F[FLAG_C];

  // 9-bit/5-bit widths expose carry (add) or borrow (sub) in the top bit
  assign add9  = {1'b0, x8} + {1'b0, y8} + {8'h00, cin};
  assign addh  = {1'b0, x8[3:0]} + {1'b0, y8[3:0]} + {4'h0, cin};
  assign sub9  = {1'b0, x8} - {1'b0, y8} - {8'h00, cin};
  assign subh  = {1'b0, x8[3:0]} - {1'b0, y8[3:0]} - {4'h0, cin};
  assign add17 = {1'b0, bus.X} + {1'b0, bus.Y};
  assign add13 = {1'b0, bus.X[11:0]} + {1'b0, bus.Y[11:0]};

  alu_daa u_daa (
    .a_i (x8),
    .n_i (bus.F[FLAG_N]),
    .h_i (bus.F[FLAG_H]),
    .c_i (bus.F[FLAG_C]),
    .r_o (daa_r),
    .c_o (daa_c)
  );

  always_comb begin
    sh_r = x8;
    sh_c = 1'b0;
    case (bus.op)
      OP_RLC:  begin sh_r = {x8[6:0], x8[7]};          sh_c = x8[7]; end
      OP_RRC:  begin sh_r = {x8[0], x8[7:1]};          sh_c = x8[0]; end
      OP_RL:   begin sh_r = {x8[6:0], bus.F[FLAG_C]};  sh_c = x8[7]; end
      OP_RR:   begin sh_r = {bus.F[FLAG_C], x8[7:1]};  sh_c = x8[0]; end
      OP_SLA:  begin sh_r = {x8[6:0], 1'b0};           sh_c = x8[7]; end
      OP_SRA:  begin sh_r = {x8[7], x8[7:1]};          sh_c = x8[0]; end
      OP_SRL:  begin sh_r = {1'b0, x8[7:1]};           sh_c = x8[0]; end
      default: ;
    endcase
  end

  always_comb begin
    o_d = bus.X;
    f_d = bus.F;
    case (bus.op)
      OP_ADD, OP_ADC: begin
        o_d = {8'h00, add9[7:0]};
        f_d = {is_zero(add9[7:0]), 1'b0, addh[4], add9[8]};
      end
      OP_SUB, OP_SBC: begin
        o_d = {8'h00, sub9[7:0]};
        f_d = {is_zero(sub9[7:0]), 1'b1, subh[4], sub9[8]};
      end
      OP_CP: begin
        o_d = {8'h00, x8};
        f_d = {is_zero(sub9[7:0]), 1'b1, subh[4], sub9[8]};
      end
      OP_AND: begin
        o_d = {8'h00, x8 & y8};
        f_d = {is_zero(x8 & y8), 3'b010};
      end
      OP_XOR: begin
        o_d = {8'h00, x8 ^ y8};
        f_d = {is_zero(x8 ^ y8), 3'b000};
      end
      OP_OR: begin
        o_d = {8'h00, x8 | y8};
        f_d = {is_zero(x8 | y8), 3'b000};
      end
      OP_RLC, OP_RRC, OP_RL, OP_RR, OP_SLA, OP_SRA, OP_SRL: begin
        o_d = {8'h00, sh_r};
        f_d = {is_zero(sh_r), 2'b00, sh_c};
      end
      OP_SWAP: begin
        o_d = {8'h00, x8[3:0], x8[7:4]};
        f_d = {is_zero(x8), 3'b000};
      end
      OP_DAA: begin
        o_d = {8'h00, daa_r};
        f_d = {is_zero(daa_r), bus.F[FLAG_N], 1'b0, daa_c};
      end
      OP_CPL: begin
        o_d = {8'h00, ~x8};
        f_d = {bus.F[FLAG_Z], 2'b11, bus.F[FLAG_C]};
      end
      OP_SCF: begin
        o_d = {8'h00, x8};
        f_d = {bus.F[FLAG_Z], 3'b001};
      end
      OP_CCF: begin
        o_d = {8'h00, x8};
        f_d = {bus.F[FLAG_Z], 2'b00, ~bus.F[FLAG_C]};
      end
      OP_ADD16: begin
        o_d = add17[15:0];
        f_d = {bus.F[FLAG_Z], 1'b0, add13[12], add17[16]};
      end
      default: begin
`ifdef ALU_BITOPS_EN
        // op[2:0] selects the bit; op[7:3] selects BIT/RES/SET
        if (bus.op[7:3] == OP_BIT[7:3]) begin
          o_d = {8'h00, x8};
          f_d = {~x8[bus.op[2:0]], 2'b01, bus.F[FLAG_C]};
        end else if (bus.op[7:3] == OP_RES[7:3]) begin
          o_d = {8'h00, x8 & ~(8'h01 << bus.op[2:0])};
        end else if (bus.op[7:3] == OP_SET[7:3]) begin
          o_d = {8'h00, x8 | (8'h01 << bus.op[2:0])};
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q <= '0;
      f_q <= '0;
    end else begin
      o_q <= o_d;
      f_q <= f_d;
    end
  end

  assign bus.O       = o_q;
  assign bus.FResult = f_q;
endmodule

// File: tb/tb_alu.sv
module tb_alu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  bit done = 1'b0;

  alu_if bus();
  alu dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Behavioural reference: integer arithmetic straight from the op rules.
  function automatic logic [19:0] model(input logic [7:0] op, input logic [15:0] x,
                                        input logic [15:0] y, input logic [3:0] f);
    int a, b, c, r, cin, h, cy, z;
    logic [15:0] o;
    logic [3:0] fo;
    a = int'(x[7:0]); b = int'(y[7:0]); c = int'(f[0]);
    o = x; fo = f;
    r = 0; h = 0; cy = 0;
    if (op <= 8'h03) begin
      cin = (op == 8'h01 || op == 8'h03) ? c : 0;
      if (op <= 8'h01) begin
        r = a + b + cin; h = ((a % 16) + (b % 16) + cin > 15) ? 1 : 0; cy = (r > 255) ? 1 : 0;
      end else begin
        r = a - b - cin; h = ((a % 16) - (b % 16) - cin < 0) ? 1 : 0; cy = (r < 0) ? 1 : 0;
      end
      r = (r + 256) % 256;
      o = 16'(r);
      fo = {r == 0, op >= 8'h02, h == 1, cy == 1};
    end else if (op == 8'h07) begin
      r = (a - b + 256) % 256;
      o = 16'(a);
      fo = {r == 0, 1'b1, (a % 16) < (b % 16), a < b};
    end else if (op >= 8'h04 && op <= 8'h06) begin
      r = (op == 8'h04) ? (a & b) : (op == 8'h05) ? (a ^ b) : (a | b);
      o = 16'(r);
      fo = {r == 0, 1'b0, op == 8'h04, 1'b0};
    end else if ((op >= 8'h08 && op <= 8'h0B) || (op >= 8'h10 && op <= 8'h12)) begin
      case (op)
        8'h08: begin r = (a * 2) % 256 + a / 128; cy = a / 128; end
        8'h09: begin r = a / 2 + (a % 2) * 128;   cy = a % 2; end
        8'h0A: begin r = (a * 2) % 256 + c;       cy = a / 128; end
        8'h0B: begin r = a / 2 + c * 128;         cy = a % 2; end
        8'h10: begin r = (a * 2) % 256;           cy = a / 128; end
        8'h11: begin r = a / 2 + (a / 128) * 128; cy = a % 2; end
        default: begin r = a / 2;                 cy = a % 2; end
      endcase
      o = 16'(r);
      fo = {r == 0, 2'b00, cy == 1};
    end else if (op == 8'h13) begin
      r = (a % 16) * 16 + a / 16;
      o = 16'(r);
      fo = {r == 0, 3'b000};
    end else if (op == 8'h0C) begin
      r = a; cy = c;
      if (f[2] == 1'b0) begin
        if (c == 1 || a > 153) begin r = r + 96; cy = 1; end
        if (f[1] == 1'b1 || (a % 16) > 9) r = r + 6;
      end else begin
        if (c == 1) r = r - 96;
        if (f[1] == 1'b1) r = r - 6;
      end
      r = (r + 512) % 256;
      o = 16'(r);
      fo = {r == 0, f[2], 1'b0, cy == 1};
    end else if (op == 8'h0D) begin
      o = 16'(255 - a);
      fo = {f[3], 2'b11, f[0]};
    end else if (op == 8'h0E || op == 8'h0F) begin
      o = 16'(a);
      fo = {f[3], 2'b00, (op == 8'h0E) ? 1'b1 : ~f[0]};
    end else if (op == 8'h14) begin
      r = int'(x) + int'(y);
      o = 16'(r % 65536);
      fo = {f[3], 1'b0, (int'(x) % 4096) + (int'(y) % 4096) > 4095, r > 65535};
`ifdef ALU_BITOPS_EN
    end else if (op >= 8'h18 && op <= 8'h2F) begin
      z = 1 << (int'(op) % 8);
      if (op < 8'h20) begin
        o = 16'(a);
        fo = {(a & z) == 0, 2'b01, f[0]};
      end else if (op < 8'h28) o = 16'(a & (255 - z));
      else                     o = 16'(a | z);
`endif
    end
    return {o, fo};
  endfunction

  task automatic drive(input logic [7:0] op, input logic [15:0] x,
                       input logic [15:0] y, input logic [3:0] f);
    @(negedge clk); #2;
    bus.op = op; bus.X = x; bus.Y = y; bus.F = f;
  endtask

  task automatic check(input string name, input logic [15:0] eo, input logic [3:0] ef);
    total++;
    if (bus.O !== eo || bus.FResult !== ef) begin
      bad++;
      $display("FAIL %s: got O=%h F=%b want O=%h F=%b", name, bus.O, bus.FResult, eo, ef);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  initial begin
    logic [19:0] exp;
    bit have;
    while (!done) begin
      @(posedge clk);
      have = rst_n;
      exp = model(bus.op, bus.X, bus.Y, bus.F);
      @(negedge clk);
      if (have && rst_n && !done) check("model", exp[19:4], exp[3:0]);
    end
  end

  typedef struct {
    string name; logic [7:0] op; logic [15:0] x, y; logic [3:0] f;
    logic [15:0] eo; logic [3:0] ef;
  } vec_t;

  vec_t vecs[$];
  logic [15:0] px[6] = '{16'h0000, 16'h12FF, 16'hFF99, 16'h8A0F, 16'h0055, 16'hF000};
  logic [15:0] py[6] = '{16'h0000, 16'h3401, 16'h0066, 16'h7581, 16'h00AA, 16'h1000};
  logic [3:0]  pf[6] = '{4'h0, 4'hF, 4'h5, 4'hA, 4'h6, 4'h9};

  initial begin
    vecs.push_back('{"add",    8'h00, 16'h003A, 16'h00C6, 4'b0000, 16'h0000, 4'b1011});
    vecs.push_back('{"sbc",    8'h03, 16'h003B, 16'h002A, 4'b0001, 16'h0010, 4'b0100});
    vecs.push_back('{"sub",    8'h02, 16'h003E, 16'h003E, 4'b0000, 16'h0000, 4'b1100});
    vecs.push_back('{"daa",    8'h0C, 16'h007D, 16'h0000, 4'b0000, 16'h0083, 4'b0000});
    vecs.push_back('{"daa_n",  8'h0C, 16'h000F, 16'h0000, 4'b0110, 16'h0009, 4'b0100});
    vecs.push_back('{"rlc",    8'h08, 16'h0085, 16'h0000, 4'b0000, 16'h000B, 4'b0001});
    vecs.push_back('{"add16a", 8'h14, 16'h8A23, 16'h0605, 4'b1000, 16'h9028, 4'b1010});
    vecs.push_back('{"add16b", 8'h14, 16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 4'b0011});
`ifdef ALU_BITOPS_EN
    vecs.push_back('{"bit7",   8'h1F, 16'h007F, 16'h0000, 4'b0001, 16'h007F, 4'b1011});
    vecs.push_back('{"set0",   8'h28, 16'h0080, 16'h0000, 4'b0101, 16'h0081, 4'b0101});
`else
    vecs.push_back('{"bit7",   8'h1F, 16'h007F, 16'h0000, 4'b0001, 16'h007F, 4'b0001});
    vecs.push_back('{"set0",   8'h28, 16'h0080, 16'h0000, 4'b0101, 16'h0080, 4'b0101});
`endif
    vecs.push_back('{"undef",  8'h7F, 16'h1234, 16'h5678, 4'b1010, 16'h1234, 4'b1010});
    vecs.push_back('{"cp",     8'h07, 16'h0010, 16'h0020, 4'b0000, 16'h0010, 4'b0101});
    vecs.push_back('{"rr",     8'h0B, 16'h0001, 16'h0000, 4'b0001, 16'h0080, 4'b0001});
    vecs.push_back('{"sra",    8'h11, 16'h0081, 16'h0000, 4'b0000, 16'h00C0, 4'b0001});
    vecs.push_back('{"swap",   8'h13, 16'h00F1, 16'h0000, 4'b1111, 16'h001F, 4'b0000});
    vecs.push_back('{"and",    8'h04, 16'h12F0, 16'h000F, 4'b0000, 16'h0000, 4'b1010});
    vecs.push_back('{"adc",    8'h01, 16'h000F, 16'h0000, 4'b0001, 16'h0010, 4'b0010});
    vecs.push_back('{"ccf",    8'h0F, 16'h00AA, 16'h0000, 4'b1001, 16'h00AA, 4'b1000});

    // Reset state with live inputs present
    bus.op = 8'h00; bus.X = 16'h0012; bus.Y = 16'h0034; bus.F = 4'hF;
    #3;
    check("reset", 16'h0000, 4'b0000);
    @(posedge clk); #1;
    check("reset_hold", 16'h0000, 4'b0000);
    @(negedge clk); rst_n = 1'b1;

    // Directed literal vectors (pin both DUT and model)
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].f);
      @(posedge clk); #1;
      check(vecs[i].name, vecs[i].eo, vecs[i].ef);
    end

    // Op sweep; checked by the model process each cycle
    for (int op = 0; op <= 8'h2F; op++)
      for (int j = 0; j < 6; j++)
        drive(8'(op), px[j], py[j], pf[(op + j) % 6]);
    for (int j = 0; j < 6; j++) drive(8'h7F, px[j], py[j], pf[j]);

    // Reset mid-sequence: result discarded immediately, resumes after release
    drive(8'h00, 16'h0001, 16'h0002, 4'b0000);
    @(posedge clk); #1;
    check("pre_rst", 16'h0003, 4'b0000);
    #2 rst_n = 1'b0;
    #1 check("mid_rst", 16'h0000, 4'b0000);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst", 16'h0003, 4'b0000);

    @(negedge clk);
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu.md
# alu

Combinational-core, output-registered LR35902 (Game Boy) arithmetic/logic unit. Executes the 8-bit ALU, rotate/shift, BCD, flag, single-bit and 16-bit add operations of the CPU datapath. Takes two 16-bit operands and the current flag nibble; returns a 16-bit result and a new flag nibble. Sits between the register file and the CPU control sequencer.

## Interface
- No parameters.
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- op  in  8  operation code (alu_pkg)
- X  in  16  first operand; 8-bit ops use X[7:0]
- Y  in  16  second operand; 8-bit ops use Y[7:0]
- F  in  4  incoming flags {Z,N,H,C} (bit3..bit0)
- FResult  out  4  resulting flags {Z,N,H,C}
- O  out  16  result; 8-bit ops drive O[15:8]=0

## Operation
- Op codes: ADD 0x00, ADC 0x01, SUB 0x02, SBC 0x03, AND 0x04, XOR 0x05, OR 0x06, CP 0x07, RLC 0x08, RRC 0x09, RL 0x0A, RR 0x0B, DAA 0x0C, CPL 0x0D, SCF 0x0E, CCF 0x0F, SLA 0x10, SRA 0x11, SRL 0x12, SWAP 0x13, ADD16 0x14, BIT+n 0x18–0x1F, RES+n 0x20–0x27, SET+n 0x28–0x2F (n = bit index 0–7).
- Z = (O[7:0]==0) wherever "Z by result" applies.
- ADD/ADC: X+Y(+C); Z by result, N=0, H=carry out of bit 3, C=carry out of bit 7.
- SUB/SBC: X−Y(−C); Z by result, N=1, H=borrow from bit 4, C=borrow. CP: flags as SUB, O=X.
- AND: Z,0,1,0. XOR/OR: Z,0,0,0.
- RLC/RRC/RL/RR/SLA/SRA/SRL: CB-prefix semantics on X[7:0]; C=bit shifted out, Z by result, N=H=0. RL/RR rotate through incoming C. SRA keeps bit 7.
- SWAP: nibble swap; Z by result, N=H=C=0.
- DAA: standard LR35902 correction using incoming N,H,C; N kept, H=0, C set if 0x60 adjust applied or C was set, Z by result.
- CPL: O=~X; N=H=1, Z,C kept. SCF: O=X; N=H=0, C=1. CCF: O=X; N=H=0, C=~C.
- ADD16: O=X+Y (16-bit, wraps); Z kept, N=0, H=carry out of bit 11, C=carry out of bit 15.
- BIT n: O=X; Z=~X[n], N=0, H=1, C kept. RES n / SET n: O=X with bit n cleared/set; flags unchanged.
- Unassigned op codes: O=X, FResult=F.

## Timing
- Result and flags computed combinationally, captured into O/FResult on rising clk; latency exactly 1 cycle, new op accepted every cycle, no handshake.
- rst_n low: O=0x0000, FResult=4'b0000 immediately, regardless of clk; held until first rising edge after deassertion.
- Reset asserted mid-sequence discards in-flight result.

## Configuration
- ALU_BITOPS_EN defined: BIT/RES/SET implemented as above.
- Not defined: op codes 0x18–0x2F behave as unassigned (O=X, FResult=F); bit-mask logic omitted.

## Structure
- Package alu_pkg: op-code localparams, flag bit indices (FLAG_Z=3, FLAG_N=2, FLAG_H=1, FLAG_C=0).
- Sub-module alu_daa: combinational DAA corrector (8-bit in, N/H/C in; 8-bit out, C out).
- Top: op decode, adders, shifter, output registers.

## Test plan
- ADD X=0x003A Y=0x00C6 F=0000 -> next cycle O=0x0000, FResult=1011.
- SBC X=0x003B Y=0x002A F=0001 -> O=0x0010, FResult=0100. SUB X=Y=0x003E -> O=0x0000, FResult=1100.
- DAA X=0x007D F=0000 -> O=0x0083, FResult=0000; RLC X=0x0085 -> O=0x000B, FResult=0001.
- ADD16 X=0x8A23 Y=0x0605 F=1000 -> O=0x9028, FResult=1010; X=0xFFFF Y=0x0001 F=0000 -> O=0x0000, FResult=0011.
- BIT7 X=0x007F F=0001 -> O=0x007F, FResult=1011; SET0 X=0x0080 -> O=0x0081, flags=F; undefined op 0x7F -> O=X, FResult=F.
- Drive ADD producing nonzero result, assert rst_n low between edges -> O=0x0000, FResult=0000 at once; release -> next edge resumes normal results.
